// File: rtl/md_pkg.sv
// Shared multiply/divide definitions used by Decode, Hazard and mult_div_unit.
// The MADD/MADDU/MSUB/MSUBU group is long-running only when MDU_MADD_EN is defined.
package md_pkg;

    // md_op encoding carried from Decode to the Execution stage
    typedef enum logic [3:0] {
        MD_MULT  = 4'd0,
        MD_MULTU = 4'd1,
        MD_DIV   = 4'd2,
        MD_DIVU  = 4'd3,
        MD_MTHI  = 4'd4,
        MD_MTLO  = 4'd5,
        MD_MADD  = 4'd6,
        MD_MADDU = 4'd7,
        MD_MSUB  = 4'd8,
        MD_MSUBU = 4'd9
    } md_op_e;

    // Control state of the multiply/divide sequencer
    typedef enum logic {
        MD_S_IDLE = 1'b0,
        MD_S_RUN  = 1'b1
    } md_state_e;

    // True for ops that occupy the unit for several cycles; Hazard stalls
    // MFHI/MFLO and further md ops while such an op is starting or running.
    function automatic logic md_is_long(input logic [3:0] op);
        logic w_long;
        w_long = 1'b0;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: w_long = 1'b1;
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: w_long = 1'b1;
`endif
            default: w_long = 1'b0;
        endcase
        return w_long;
    endfunction

endpackage

// File: rtl/md_counter.sv
// Busy-cycle down-counter for mult_div_unit: loads N, decrements to zero,
// and flags the final busy cycle (count == 1).
module md_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_last
);

    logic [CNT_W-1:0] r_cnt;

    // Load on request, otherwise count down and park at zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers (Execution stage).
// Operands are latched on an accepted start; the product/quotient is formed
// combinationally from the latched operands and written to HI/LO on the edge
// that closes the last busy cycle. Optional feature macro: MDU_MADD_EN adds
// MADD/MADDU/MSUB/MSUBU accumulate ops; without it codes 6..9 are no-ops.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // Signed 32x32 -> 64 product
    function automatic logic signed [63:0] mul_s(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] w_a;
        logic signed [63:0] w_b;
        w_a = {{32{a[31]}}, a};
        w_b = {{32{b[31]}}, b};
        return w_a * w_b;
    endfunction

    // Unsigned 32x32 -> 64 product
    function automatic logic [63:0] mul_u(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] w_a;
        logic [63:0] w_b;
        w_a = {32'd0, a};
        w_b = {32'd0, b};
        return w_a * w_b;
    endfunction

    // Unsigned divide, packed as {remainder, quotient}; zero divisor yields 0
    function automatic logic [63:0] div_u(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] w_q;
        logic [31:0] w_r;
        if (b == 32'd0) begin
            w_q = '0;
            w_r = '0;
        end else begin
            w_q = a / b;
            w_r = a % b;
        end
        return {w_r, w_q};
    endfunction

    // Signed divide via magnitudes: quotient truncates toward zero, remainder
    // takes the dividend's sign. 0x80000000 / -1 wraps to 0x80000000, rem 0.
    function automatic logic [63:0] div_s(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] w_ma;
        logic [31:0] w_mb;
        logic [63:0] w_qr;
        logic [31:0] w_q;
        logic [31:0] w_r;
        w_ma = a[31] ? (~a + 32'd1) : a;
        w_mb = b[31] ? (~b + 32'd1) : b;
        w_qr = div_u(w_ma, w_mb);
        w_q  = (a[31] ^ b[31]) ? (~w_qr[31:0] + 32'd1) : w_qr[31:0];
        w_r  = a[31] ? (~w_qr[63:32] + 32'd1) : w_qr[63:32];
        return {w_r, w_q};
    endfunction

    md_state_e        r_state;
    md_state_e        w_state_nxt;
    logic [3:0]       r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic             w_idle;
    logic             w_accept;
    logic             w_mthi;
    logic             w_mtlo;
    logic             w_is_div;
    logic [CNT_W-1:0] w_load_val;
    logic             w_cnt_last;
    logic             w_done;
    logic             w_res_we;
    logic [63:0]      w_res;

    assign w_idle     = (r_state == MD_S_IDLE);
    assign w_accept   = w_idle && start && md_is_long(md_op);
    assign w_mthi     = w_idle && start && (md_op == MD_MTHI);
    assign w_mtlo     = w_idle && start && (md_op == MD_MTLO);
    assign w_is_div   = (md_op == MD_DIV) || (md_op == MD_DIVU);
    assign w_load_val = w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    assign w_done     = (r_state == MD_S_RUN) && w_cnt_last;

    md_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_accept),
        .i_load_val (w_load_val),
        .o_last     (w_cnt_last)
    );

    // Sequencer state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= MD_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: leave IDLE on an accepted long op, return after the last busy cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MD_S_IDLE: if (w_accept)   w_state_nxt = MD_S_RUN;
            MD_S_RUN:  if (w_cnt_last) w_state_nxt = MD_S_IDLE;
            default:                   w_state_nxt = MD_S_IDLE;
        endcase
    end

    // Capture the op and operands when a long op is accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op <= '0;
            r_a  <= '0;
            r_b  <= '0;
        end else if (w_accept) begin
            r_op <= md_op;
            r_a  <= src_a;
            r_b  <= src_b;
        end
    end

    // Result selection from latched operands; divide-by-zero leaves HI/LO alone
    always_comb begin
        w_res    = {r_hi, r_lo};
        w_res_we = 1'b1;
        case (r_op)
            MD_MULT:  w_res = mul_s(r_a, r_b);
            MD_MULTU: w_res = mul_u(r_a, r_b);
            MD_DIV: begin
                w_res    = div_s(r_a, r_b);
                w_res_we = (r_b != 32'd0);
            end
            MD_DIVU: begin
                w_res    = div_u(r_a, r_b);
                w_res_we = (r_b != 32'd0);
            end
`ifdef MDU_MADD_EN
            MD_MADD:  w_res = {r_hi, r_lo} + mul_s(r_a, r_b);
            MD_MADDU: w_res = {r_hi, r_lo} + mul_u(r_a, r_b);
            MD_MSUB:  w_res = {r_hi, r_lo} - mul_s(r_a, r_b);
            MD_MSUBU: w_res = {r_hi, r_lo} - mul_u(r_a, r_b);
`endif
            default:  w_res_we = 1'b0;
        endcase
    end

    // HI/LO update: long-op completion, or MTHI/MTLO while idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_done) begin
            if (w_res_we) begin
                r_hi <= w_res[63:32];
                r_lo <= w_res[31:0];
            end
        end else if (w_mthi) begin
            r_hi <= src_a;
        end else if (w_mtlo) begin
            r_lo <= src_a;
        end
    end

    assign busy = (r_state == MD_S_RUN);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: long ops push expected HI/LO and busy
// length; a negedge monitor pops and compares when busy falls.
module tb_mult_div_unit;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd7;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MSUB  = 4'd8;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   errors;

    mult_div_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: count busy cycles, compare on the busy falling edge
    initial begin : monitor
        logic prev_busy;
        int   bcnt;
        exp_t e;
        prev_busy = 1'b0;
        bcnt      = 0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                bcnt++;
            end else if (prev_busy) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: busy fell with empty scoreboard, hi=0x%08h lo=0x%08h", hi, lo);
                end else begin
                    e = q.pop_front();
                    check({e.name, "_hi"}, hi, e.hi);
                    check({e.name, "_lo"}, lo, e.lo);
                    check({e.name, "_cycles"}, 32'(bcnt), 32'(e.cycles));
                end
                bcnt = 0;
            end
            prev_busy = (busy === 1'b1);
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        start = 1'b1;
        md_op = op;
        src_a = a;
        src_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", name, n);
        end
        @(negedge clk);
    endtask

    task automatic run_long(input string name, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                            input int cyc);
        exp_t e;
        e.name = name; e.hi = ehi; e.lo = elo; e.cycles = cyc;
        q.push_back(e);
        issue(op, a, b);
        wait_idle(name);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin : stim
        exp_t e;
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        start  = 1'b0;
        md_op  = '0;
        src_a  = '0;
        src_b  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_long("mult_neg",   OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5);
        run_long("multu_max",  OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5);
        run_long("div_neg",    OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        run_long("divu_small", OP_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        10);
        run_long("div_ovf",    OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 10);

        // MTHI/MTLO take effect on the next edge with no busy
        issue(OP_MTHI, 32'h11, 32'h0);
        check("mthi_hi", hi, 32'h11);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        issue(OP_MTLO, 32'h22, 32'h0);
        check("mtlo_lo", lo, 32'h22);

        run_long("div_by_zero", OP_DIV, 32'd1234, 32'd0, 32'h11, 32'h22, 10);

        // MTLO during a DIV is ignored; operand changes after start are ignored
        e.name = "div_mtlo_busy"; e.hi = 32'd2; e.lo = 32'd14; e.cycles = 10;
        q.push_back(e);
        issue(OP_DIV, 32'd100, 32'd7);
        issue(OP_MTLO, 32'hABCD, 32'h0);
        src_a = 32'hDEADBEEF;
        src_b = 32'h3;
        wait_idle("div_mtlo_busy");

        // Undefined code: no busy, HI/LO unchanged
        issue(4'hF, 32'h1234, 32'h5678);
        check("undef_busy", {31'd0, busy}, 32'd0);
        check("undef_hi", hi, 32'd2);
        check("undef_lo", lo, 32'd14);

        // Accumulate group
        issue(OP_MTHI, 32'h0, 32'h0);
        issue(OP_MTLO, 32'hFFFFFFFF, 32'h0);
`ifdef MDU_MADD_EN
        run_long("maddu_carry", OP_MADDU, 32'd1, 32'd1, 32'd1, 32'd0, 5);
        run_long("msub_borrow", OP_MSUB,  32'd2, 32'd3, 32'd0, 32'hFFFFFFFA, 5);
`else
        issue(OP_MADDU, 32'd1, 32'd1);
        check("maddu_off_busy", {31'd0, busy}, 32'd0);
        check("maddu_off_hi", hi, 32'd0);
        check("maddu_off_lo", lo, 32'hFFFFFFFF);
`endif

        // Reset abort in the third busy cycle of a MULT
        issue(OP_MTHI, 32'h55, 32'h0);
        issue(OP_MTLO, 32'h66, 32'h0);
        e.name = "abort"; e.hi = 32'd0; e.lo = 32'd0; e.cycles = 2;
        q.push_back(e);
        issue(OP_MULT, 32'd3, 32'd4);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("abort_late_busy", {31'd0, busy}, 32'd0);
        check("abort_late_hi", hi, 32'd0);
        check("abort_late_lo", lo, 32'd0);

        @(negedge clk);
        check("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
